// File: rtl/adf_pll_pkg.sv
// adf_pll_pkg: shared constants and FSM state type for the ADF PLL serial
// writer slice (top adf_pll_serial_writer, FIFO pll_word_fifo, host interface).
//   PLL_WORD_W     : bits per ADF register word (shifted MSB first)
//   PLL_FIFO_DEPTH : default number of queued words
//   PLL_LE_TICKS   : default PLL_LE high width in TICK_FALL strobes
package adf_pll_pkg;

    localparam int PLL_WORD_W     = 32;
    localparam int PLL_FIFO_DEPTH = 8;
    localparam int PLL_LE_TICKS   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } pll_state_e;

endpackage

// File: rtl/adf_pll_serial_writer_if.sv
// adf_pll_serial_writer_if: host-side bundle of the PLL serial writer.
//   WR_EN/WR_DATA : word push from the host (command decoder)
//   LEVEL         : words queued, FULL: queue full
//   OVERFLOW      : sticky, a push was dropped while full
//   BUSY          : queue non-empty or a word in flight
//   DONE          : 1-CLK pulse when a word has been latched
// master = host side, slave = writer side.
interface adf_pll_serial_writer_if
    import adf_pll_pkg::*;
#(
    parameter int WORD_W     = PLL_WORD_W,
    parameter int FIFO_DEPTH = PLL_FIFO_DEPTH
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              WR_EN;
    logic [WORD_W-1:0] WR_DATA;
    logic [LVL_W-1:0]  LEVEL;
    logic              FULL;
    logic              OVERFLOW;
    logic              BUSY;
    logic              DONE;

    modport master (
        output WR_EN, WR_DATA,
        input  LEVEL, FULL, OVERFLOW, BUSY, DONE
    );

    modport slave (
        input  WR_EN, WR_DATA,
        output LEVEL, FULL, OVERFLOW, BUSY, DONE
    );

endinterface

// File: rtl/pll_word_fifo.sv
// pll_word_fifo: synchronous word FIFO feeding the PLL shifter.
//   CLK, RST       : clock, async active-low reset (empties the queue)
//   push/push_data : write request; accepted if not full or if a pop
//                    happens in the same cycle
//   pop/pop_data   : read request (ignored when empty); pop_data shows the
//                    head word combinationally
//   level/full     : registered occupancy, updated the cycle after push/pop
//   empty          : head valid indication (decoded from level register)
//   overflow       : sticky, set when a push is dropped; cleared by reset
module pll_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LW-1:0]    level_nxt;

    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full queue is fine
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop)
            level_nxt = level + LW'(1);
        else if (do_pop && !do_push)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // storage has no reset; the pointers define what is valid
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adf_pll_serial_writer.sv
// adf_pll_serial_writer: serialises queued ADF PLL register words onto the
// 3-wire PLL bus (PLL_CLK, PLL_DATA, PLL_LE), MSB first.
//   CLK, RST             : system clock, async active-low reset
//   TICK_RISE/TICK_FALL  : 1-CLK phase strobes from the clock divider; the bus
//                          rate is the strobe rate. FALL wins if both are high.
//   host (slave modport) : WR_EN/WR_DATA push, LEVEL/FULL/OVERFLOW/BUSY/DONE
//   PLL_CLK/DATA/LE      : registered bus outputs
// Per word: IDLE pops, SYNC waits a fall to present the MSB, SHIFT emits
// WORD_W clock pulses, LATCH raises LE on the next rise and drops it after
// LE_TICKS falls, pulsing DONE.
module adf_pll_serial_writer
    import adf_pll_pkg::*;
#(
    parameter int WORD_W     = PLL_WORD_W,
    parameter int FIFO_DEPTH = PLL_FIFO_DEPTH,
    parameter int LE_TICKS   = PLL_LE_TICKS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    TICK_RISE,
    input  logic                    TICK_FALL,
    adf_pll_serial_writer_if.slave  host,
    output logic                    PLL_CLK,
    output logic                    PLL_DATA,
    output logic                    PLL_LE
);
    localparam int BW  = $clog2(WORD_W);
    localparam int LEW = $clog2(LE_TICKS + 1);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    pll_state_e        state;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bitcnt;
    logic [LEW-1:0]    lecnt;
    logic [LEW-1:0]    lecnt_inc;
    logic              busy_q;
    logic              done_q;

    logic              fall;
    logic              rise;
    logic              pop;
    logic [WORD_W-1:0] pop_data;
    logic [LW-1:0]     fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ovf;

    // simultaneous strobes count as a fall only
    assign fall      = TICK_FALL;
    assign rise      = TICK_RISE && !TICK_FALL;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign lecnt_inc = lecnt + LEW'(1);

    pll_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (host.WR_EN),
        .push_data (host.WR_DATA),
        .pop       (pop),
        .pop_data  (pop_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    assign host.LEVEL    = fifo_level;
    assign host.FULL     = fifo_full;
    assign host.OVERFLOW = fifo_ovf;
    assign host.BUSY     = busy_q;
    assign host.DONE     = done_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            lecnt    <= '0;
            PLL_CLK  <= 1'b0;
            PLL_DATA <= 1'b0;
            PLL_LE   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // lags the queue/state by one cycle, so BUSY drops after DONE
            busy_q <= !fifo_empty || (state != IDLE);
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg  <= pop_data;
                        bitcnt <= BW'(WORD_W - 1);
                        state  <= SYNC;
                    end
                end
                // wait a fall so the first rise always follows a full low phase
                SYNC: begin
                    if (fall) begin
                        PLL_DATA <= shreg[WORD_W-1];
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        PLL_CLK <= 1'b0;
                        if (bitcnt == '0) begin
                            PLL_DATA <= 1'b0;
                            lecnt    <= '0;
                            state    <= LATCH;
                        end else begin
                            shreg    <= {shreg[WORD_W-2:0], 1'b0};
                            PLL_DATA <= shreg[WORD_W-2];
                            bitcnt   <= bitcnt - BW'(1);
                        end
                    end else if (rise) begin
                        PLL_CLK <= 1'b1;
                    end
                end
                LATCH: begin
                    // falls before LE goes high do not count toward its width
                    if (fall && PLL_LE) begin
                        lecnt <= lecnt_inc;
                        if (lecnt_inc == LEW'(LE_TICKS)) begin
                            PLL_LE <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end else if (rise && !PLL_LE) begin
                        PLL_LE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adf_pll_serial_writer.sv
module tb_adf_pll_serial_writer;
    logic CLK;
    logic RST;
    logic TICK_RISE;
    logic TICK_FALL;
    logic PLL_CLK;
    logic PLL_DATA;
    logic PLL_LE;

    int checks = 0;
    int errors = 0;

    adf_pll_serial_writer_if #(.WORD_W(32), .FIFO_DEPTH(8)) host();

    adf_pll_serial_writer #(.WORD_W(32), .FIFO_DEPTH(8), .LE_TICKS(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .TICK_RISE (TICK_RISE),
        .TICK_FALL (TICK_FALL),
        .host      (host),
        .PLL_CLK   (PLL_CLK),
        .PLL_DATA  (PLL_DATA),
        .PLL_LE    (PLL_LE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // divider model: one strobe every 4 CLK, FALL then RISE alternating
    bit tick_en    = 0;
    bit both_next  = 0;
    bit both_fired = 0;
    int tdiv       = 0;
    bit tph        = 0;
    initial begin
        TICK_RISE = 0;
        TICK_FALL = 0;
        forever begin
            @(posedge CLK);
            #1;
            TICK_RISE = 0;
            TICK_FALL = 0;
            if (tick_en) begin
                tdiv++;
                if (tdiv == 4) begin
                    tdiv = 0;
                    if (!tph) begin
                        TICK_FALL = 1;
                        if (both_next) begin
                            TICK_RISE  = 1;
                            both_next  = 0;
                            both_fired = 1;
                        end
                    end else begin
                        TICK_RISE = 1;
                    end
                    tph = !tph;
                end
            end
        end
    end

    // bus monitor: decodes bits on PLL_CLK rises, measures LE and gaps
    int cyc = 0, rises = 0, rx_bits = 0, done_cnt = 0, le_rises = 0;
    int le_run = 0, le_len = 0, le_fall_cyc = 0, min_gap = 1000000, level_max = 0;
    bit gap_armed = 0, prev_clk = 0, prev_le = 0;
    logic [31:0] rx_word = '0;
    logic [31:0] got_q[$];
    int          bits_q[$];

    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            rx_bits  = 0;
            prev_clk = 0;
            prev_le  = 0;
            le_run   = 0;
        end else begin
            if (PLL_CLK && !prev_clk) begin
                rx_word = {rx_word[30:0], PLL_DATA};
                rx_bits++;
                rises++;
                if (gap_armed) begin
                    if (cyc - le_fall_cyc < min_gap) min_gap = cyc - le_fall_cyc;
                    gap_armed = 0;
                end
            end
            if (PLL_LE) le_run++;
            if (PLL_LE && !prev_le) le_rises++;
            if (!PLL_LE && prev_le) begin
                le_len      = le_run;
                le_run      = 0;
                le_fall_cyc = cyc;
                gap_armed   = 1;
            end
            if (host.DONE) begin
                done_cnt++;
                got_q.push_back(rx_word);
                bits_q.push_back(rx_bits);
                rx_bits = 0;
            end
            if (int'(host.LEVEL) > level_max) level_max = int'(host.LEVEL);
            prev_clk = PLL_CLK;
            prev_le  = PLL_LE;
        end
    end

    logic [31:0] vec [16];
    int          nvec;

    task automatic clear_stats();
        @(negedge CLK);
        done_cnt = 0; rises = 0; le_rises = 0; level_max = 0;
        min_gap = 1000000; gap_armed = 0; le_len = 0;
        got_q.delete(); bits_q.delete();
    endtask

    task automatic push_vec();
        for (int i = 0; i < nvec; i++) begin
            @(posedge CLK); #1;
            host.WR_EN   = 1;
            host.WR_DATA = vec[i];
        end
        @(posedge CLK); #1;
        host.WR_EN = 0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if ({PLL_CLK, PLL_DATA, PLL_LE, host.DONE, host.BUSY, host.FULL, host.OVERFLOW} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {PLL_CLK, PLL_DATA, PLL_LE, host.DONE, host.BUSY, host.FULL, host.OVERFLOW});
        end
        checks++;
        if (host.LEVEL !== 4'd0) begin
            errors++;
            $display("FAIL reset_level: got %0d expected 0", host.LEVEL);
        end
        RST = 1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({PLL_CLK, PLL_LE, host.BUSY} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000", {PLL_CLK, PLL_LE, host.BUSY});
        end
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        w = 32'h00580005;
        clear_stats();
        tick_en = 1;
        nvec = 1; vec[0] = w;
        push_vec();
        for (int c = 0; c < 1000 && host.DONE !== 1'b1; c++) @(negedge CLK);
        checks++;
        if (host.DONE !== 1'b1 || host.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL single_done_busy: got done=%b busy=%b expected 1 1", host.DONE, host.BUSY);
        end
        @(negedge CLK);
        checks++;
        if (host.BUSY !== 1'b0 || host.DONE !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_fall: got busy=%b done=%b expected 0 0", host.BUSY, host.DONE);
        end
        repeat (50) @(negedge CLK);
        checks++;
        if (done_cnt != 1 || got_q.size() != 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d expected 1", done_cnt);
        end else begin
            checks++;
            if (got_q[0] !== w || bits_q[0] != 32) begin
                errors++;
                $display("FAIL single_word: got %h/%0d bits expected %h/32", got_q[0], bits_q[0], w);
            end
        end
        checks++;
        if (rises != 32) begin
            errors++;
            $display("FAIL single_rises: got %0d expected 32", rises);
        end
        // LE: up on a rise, down on the 2nd fall after it -> 3 strobe gaps of 4 CLK
        checks++;
        if (le_len != 12 || le_rises != 1) begin
            errors++;
            $display("FAIL single_le: got len=%0d rises=%0d expected 12 1", le_len, le_rises);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        nvec = 6;
        vec[0] = 32'h00580005; vec[1] = 32'h00EC803C; vec[2] = 32'h000004B3;
        vec[3] = 32'h00004E42; vec[4] = 32'h08008011; vec[5] = 32'h00A00000;
        push_vec();
        for (int c = 0; c < 4000 && done_cnt < 6; c++) @(negedge CLK);
        checks++;
        if (done_cnt != 6) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 6", done_cnt);
        end
        // first word is popped while the 2nd is pushed, so the peak is 5
        checks++;
        if (level_max != 5) begin
            errors++;
            $display("FAIL b2b_level_peak: got %0d expected 5", level_max);
        end
        checks++;
        if (rises != 192) begin
            errors++;
            $display("FAIL b2b_rises: got %0d expected 192", rises);
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== vec[i] || bits_q[i] != 32) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h/%0d expected %h/32", i, got_q[i], bits_q[i], vec[i]);
            end
        end
        checks++;
        if (min_gap < 8) begin
            errors++;
            $display("FAIL b2b_le_gap: got %0d CLK expected >= 8", min_gap);
        end
    endtask

    task automatic test_both_ticks();
        logic [31:0] w;
        w = 32'h0F0FA5C3;
        clear_stats();
        both_fired = 0;
        nvec = 1; vec[0] = w;
        push_vec();
        for (int c = 0; c < 1000 && rises < 5; c++) @(negedge CLK);
        both_next = 1;
        for (int c = 0; c < 100 && !both_fired; c++) @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (PLL_CLK !== 1'b0 || PLL_DATA !== w[26] || rises != 5) begin
            errors++;
            $display("FAIL both_ticks: got clk=%b data=%b rises=%0d expected 0 %b 5",
                     PLL_CLK, PLL_DATA, rises, w[26]);
        end
        for (int c = 0; c < 1000 && done_cnt < 1; c++) @(negedge CLK);
        checks++;
        if (done_cnt != 1 || got_q.size() != 1 || got_q[0] !== w || rises != 32) begin
            errors++;
            $display("FAIL both_word: got done=%0d rises=%0d word=%h expected 1 32 %h",
                     done_cnt, rises, (got_q.size() > 0) ? got_q[0] : 32'h0, w);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        int bad;
        w = 32'h3C5A9617;
        bad = 0;
        clear_stats();
        nvec = 1; vec[0] = w;
        push_vec();
        for (int c = 0; c < 1000 && rises < 16; c++) @(negedge CLK);
        tick_en = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            if (PLL_CLK !== 1'b1 || PLL_DATA !== w[16] || PLL_LE !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rises != 16) begin
            errors++;
            $display("FAIL stall_frozen: got %0d bad cycles rises=%0d expected 0 16", bad, rises);
        end
        tick_en = 1;
        for (int c = 0; c < 1000 && done_cnt < 1; c++) @(negedge CLK);
        checks++;
        if (done_cnt != 1 || got_q.size() != 1 || got_q[0] !== w) begin
            errors++;
            $display("FAIL stall_word: got done=%0d word=%h expected 1 %h",
                     done_cnt, (got_q.size() > 0) ? got_q[0] : 32'h0, w);
        end
    endtask

    task automatic test_overflow();
        clear_stats();
        tick_en = 0;
        nvec = 9;
        for (int i = 0; i < 9; i++) vec[i] = 32'hA5000000 + 32'(i * 32'h00010203);
        push_vec();
        @(negedge CLK);
        // word 0 was popped into the shifter, leaving 8 queued
        checks++;
        if (host.LEVEL !== 4'd8 || host.FULL !== 1'b1 || host.OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: got level=%0d full=%b ovf=%b expected 8 1 0",
                     host.LEVEL, host.FULL, host.OVERFLOW);
        end
        nvec = 1; vec[9] = vec[0]; vec[0] = 32'hDEADBEEF;
        push_vec();
        vec[0] = vec[9];
        @(negedge CLK);
        checks++;
        if (host.LEVEL !== 4'd8 || host.OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: got level=%0d ovf=%b expected 8 1", host.LEVEL, host.OVERFLOW);
        end
        tick_en = 1;
        for (int c = 0; c < 5000 && done_cnt < 9; c++) @(negedge CLK);
        repeat (600) @(negedge CLK);
        checks++;
        if (done_cnt != 9 || got_q.size() != 9) begin
            errors++;
            $display("FAIL ovf_count: got %0d words expected 9", done_cnt);
        end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== vec[i]) begin
                errors++;
                $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[i], vec[i]);
            end
        end
        checks++;
        if (host.OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", host.OVERFLOW);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        clear_stats();
        nvec = 1; vec[0] = 32'hFFFFFFFF;
        push_vec();
        for (int c = 0; c < 1000 && rises < 10; c++) @(negedge CLK);
        #2;
        RST = 0;
        #1;
        checks++;
        if ({PLL_CLK, PLL_DATA, PLL_LE} !== 3'b000) begin
            errors++;
            $display("FAIL async_bus: got %b expected 000", {PLL_CLK, PLL_DATA, PLL_LE});
        end
        checks++;
        if (host.LEVEL !== 4'd0 || host.BUSY !== 1'b0 || host.OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL async_status: got level=%0d busy=%b ovf=%b expected 0 0 0",
                     host.LEVEL, host.BUSY, host.OVERFLOW);
        end
        repeat (5) @(negedge CLK);
        RST = 1;
        repeat (300) @(negedge CLK);
        checks++;
        if (le_rises != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL async_no_latch: got le_rises=%0d done=%0d expected 0 0", le_rises, done_cnt);
        end
        w = 32'h12345678;
        nvec = 1; vec[0] = w;
        push_vec();
        for (int c = 0; c < 1000 && done_cnt < 1; c++) @(negedge CLK);
        checks++;
        if (done_cnt != 1 || got_q.size() != 1 || got_q[0] !== w || bits_q[0] != 32) begin
            errors++;
            $display("FAIL async_next_word: got done=%0d word=%h expected 1 %h",
                     done_cnt, (got_q.size() > 0) ? got_q[0] : 32'h0, w);
        end
    endtask

    initial begin
        RST = 0;
        host.WR_EN = 0;
        host.WR_DATA = '0;
        repeat (3) @(posedge CLK);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_both_ticks();
        test_stall();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
